// File: rtl/enemy_fleet_grid.sv
// ============================================================================
// enemy_fleet_grid
// ----------------------------------------------------------------------------
// Controller for one row of NUM_ENEMIES enemies that move as a single block.
// The block steps sideways once per move period and drops down when the
// outermost alive enemy would cross a bound. A player projectile destroys the
// lowest-indexed alive enemy whose hitbox it lies in. The move period shrinks
// as enemies die. The game ends in WIN when every enemy is dead, or in LOSE
// when the fleet descends to LOSE_V.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   start        in   leave INIT / restart from WIN or LOSE
//   proj_valid   in   projectile position valid this cycle
//   proj_h       in   projectile horizontal position
//   proj_v       in   projectile vertical position
//   fleet_h      out  origin h of enemy 0 (enemy i at fleet_h + i*SPACING_H)
//   fleet_v      out  origin v shared by all enemies
//   alive_mask   out  bit i set while enemy i is alive
//   alive_count  out  number of alive enemies
//   hit_pulse    out  one-cycle pulse when an enemy is destroyed
//   hit_index    out  index of the destroyed enemy, valid with hit_pulse
//   win          out  all enemies destroyed (level)
//   lose         out  fleet reached LOSE_V (level)
// ============================================================================
module enemy_fleet_grid #(
    parameter int NUM_ENEMIES = 8,
    parameter int SPACING_H   = 60,
    parameter int ENEMY_W     = 40,
    parameter int ENEMY_H     = 30,
    parameter int STEP_H      = 10,
    parameter int STEP_V      = 20,
    parameter int LEFT_BOUND  = 50,
    parameter int RIGHT_BOUND = 750,
    parameter int LOSE_V      = 50,
    parameter int START_H     = 50,
    parameter int START_V     = 475,
    parameter int BASE_PERIOD = 1000000,
    parameter int PERIOD_DEC  = 100000,
    parameter int MIN_PERIOD  = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   proj_valid,
    input  logic [9:0]             proj_h,
    input  logic [9:0]             proj_v,
    output logic [9:0]             fleet_h,
    output logic [9:0]             fleet_v,
    output logic [NUM_ENEMIES-1:0] alive_mask,
    output logic [4:0]             alive_count,
    output logic                   hit_pulse,
    output logic [3:0]             hit_index,
    output logic                   win,
    output logic                   lose
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    // Geometry is compared in 12 bits so origin + width never wraps.
    localparam logic [11:0] ENEMY_W12     = 12'(ENEMY_W);
    localparam logic [11:0] ENEMY_H12     = 12'(ENEMY_H);
    localparam logic [11:0] STEP_H12      = 12'(STEP_H);
    localparam logic [11:0] LEFT_BOUND12  = 12'(LEFT_BOUND);
    localparam logic [11:0] RIGHT_BOUND12 = 12'(RIGHT_BOUND);
    localparam logic [11:0] LOSE_V12      = 12'(LOSE_V);
    localparam logic [9:0]  STEP_H10      = 10'(STEP_H);
    localparam logic [9:0]  STEP_V10      = 10'(STEP_V);
    localparam logic [9:0]  START_H10     = 10'(START_H);
    localparam logic [9:0]  START_V10     = 10'(START_V);
    localparam logic [4:0]  NUM_ENEMIES5  = 5'(NUM_ENEMIES);
    localparam logic [31:0] BASE_PERIOD32 = 32'(BASE_PERIOD);
    localparam logic [31:0] PERIOD_DEC32  = 32'(PERIOD_DEC);
    localparam logic [31:0] MIN_PERIOD32  = 32'(MIN_PERIOD);

    state_t                 state;
    state_t                 next_state;
    logic                   dir_left;
    logic [31:0]            move_count;
    logic [31:0]            period;
    logic [31:0]            dead_dec;
    logic                   hit_any;
    logic [3:0]             hit_sel;
    logic [NUM_ENEMIES-1:0] hit_onehot;
    logic [11:0]            hit_origin;
    logic [3:0]             left_idx;
    logic [3:0]             right_idx;
    logic [11:0]            left_origin;
    logic [11:0]            right_origin;
    logic                   any_alive;
    logic                   reload;
    logic                   move_now;
    logic [9:0]             fleet_v_down;

    logic [11:0] fleet_h12;
    logic [11:0] fleet_v12;
    logic [11:0] proj_h12;
    logic [11:0] proj_v12;

    assign fleet_h12 = {2'b00, fleet_h};
    assign fleet_v12 = {2'b00, fleet_v};
    assign proj_h12  = {2'b00, proj_h};
    assign proj_v12  = {2'b00, proj_v};

    assign win  = (state == WIN);
    assign lose = (state == LOSE);

    // Move period shortens by PERIOD_DEC per dead enemy, floored at MIN_PERIOD.
    // The subtraction is guarded so it can never go negative.
    always_comb begin
        dead_dec = (32'(NUM_ENEMIES5) - 32'(alive_count)) * PERIOD_DEC32;
        if ((dead_dec >= BASE_PERIOD32) || ((BASE_PERIOD32 - dead_dec) < MIN_PERIOD32))
            period = MIN_PERIOD32;
        else
            period = BASE_PERIOD32 - dead_dec;
    end

    // Scan from the top index down so the lowest overlapping enemy wins.
    always_comb begin
        hit_any    = 1'b0;
        hit_sel    = 4'd0;
        hit_onehot = '0;
        hit_origin = 12'd0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            hit_origin = fleet_h12 + 12'(i * SPACING_H);
            if (proj_valid && alive_mask[i] &&
                (proj_h12 >= hit_origin) && (proj_h12 < hit_origin + ENEMY_W12) &&
                (proj_v12 >= fleet_v12) && (proj_v12 < fleet_v12 + ENEMY_H12)) begin
                hit_any       = 1'b1;
                hit_sel       = 4'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // Edge reversal looks at the outermost enemies that are still alive,
    // so a dead enemy on the flank lets the block travel further.
    always_comb begin
        left_idx  = 4'd0;
        right_idx = 4'd0;
        any_alive = |alive_mask;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (alive_mask[i])
                left_idx = 4'(i);
        end
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (alive_mask[i])
                right_idx = 4'(i);
        end
        left_origin  = fleet_h12 + 12'(int'(left_idx) * SPACING_H);
        right_origin = fleet_h12 + 12'(int'(right_idx) * SPACING_H);
    end

    // Descending saturates at zero rather than wrapping to the bottom of the screen.
    assign fleet_v_down = (fleet_v >= STEP_V10) ? (fleet_v - STEP_V10) : 10'd0;

    // Leaving WIN/LOSE reloads on the same edge so INIT shows fresh values at once.
    assign reload   = (state == INIT) || (((state == WIN) || (state == LOSE)) && start);
    assign move_now = (state == RUN) && (move_count >= (period - 32'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= INIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT: if (start) next_state = RUN;
            RUN: begin
                if (alive_count == 5'd0)
                    next_state = WIN;
                else if (fleet_v12 <= LOSE_V12)
                    next_state = LOSE;
            end
            WIN:  if (start) next_state = INIT;
            LOSE: if (start) next_state = INIT;
            default: next_state = INIT;
        endcase
    end

    // Fleet datapath. A hit and a move on the same edge are both applied;
    // the move decision uses the mask and position from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fleet_h     <= START_H10;
            fleet_v     <= START_V10;
            alive_mask  <= '1;
            alive_count <= NUM_ENEMIES5;
            hit_pulse   <= 1'b0;
            hit_index   <= 4'd0;
            dir_left    <= 1'b0;
            move_count  <= 32'd0;
        end else if (reload) begin
            fleet_h     <= START_H10;
            fleet_v     <= START_V10;
            alive_mask  <= '1;
            alive_count <= NUM_ENEMIES5;
            hit_pulse   <= 1'b0;
            hit_index   <= 4'd0;
            dir_left    <= 1'b0;
            move_count  <= 32'd0;
        end else if (state == RUN) begin
            hit_pulse <= hit_any;
            if (hit_any) begin
                alive_mask  <= alive_mask & ~hit_onehot;
                alive_count <= alive_count - 5'd1;
                hit_index   <= hit_sel;
            end
            if (move_now) begin
                move_count <= 32'd0;
                if (any_alive) begin
                    if (!dir_left) begin
                        if (right_origin + STEP_H12 > RIGHT_BOUND12) begin
                            fleet_v  <= fleet_v_down;
                            dir_left <= 1'b1;
                        end else begin
                            fleet_h <= fleet_h + STEP_H10;
                        end
                    end else begin
                        if (left_origin < LEFT_BOUND12 + STEP_H12) begin
                            fleet_v  <= fleet_v_down;
                            dir_left <= 1'b0;
                        end else begin
                            fleet_h <= fleet_h - STEP_H10;
                        end
                    end
                end
            end else begin
                move_count <= move_count + 32'd1;
            end
        end else begin
            hit_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enemy_fleet_grid.sv
// ============================================================================
// tb_enemy_fleet_grid
// ----------------------------------------------------------------------------
// Directed bench for enemy_fleet_grid using two small instances:
//   A: 3 enemies, pitch 150, short move period that shrinks per kill.
//      Covers block motion, single hits, reversal on the outermost alive
//      enemy, win and restart.
//   B: 2 enemies with overlapping hitboxes, tight bounds, low start.
//      Covers lowest-index hit priority, descent to lose and async reset.
// ============================================================================
module tb_enemy_fleet_grid;

    logic       clk;
    logic       reset_a, start_a, proj_valid_a;
    logic [9:0] proj_h_a, proj_v_a;
    logic [9:0] fleet_h_a, fleet_v_a;
    logic [2:0] alive_mask_a;
    logic [4:0] alive_count_a;
    logic       hit_pulse_a, win_a, lose_a;
    logic [3:0] hit_index_a;

    logic       reset_b, start_b, proj_valid_b;
    logic [9:0] proj_h_b, proj_v_b;
    logic [9:0] fleet_h_b, fleet_v_b;
    logic [1:0] alive_mask_b;
    logic [4:0] alive_count_b;
    logic       hit_pulse_b, win_b, lose_b;
    logic [3:0] hit_index_b;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    enemy_fleet_grid #(
        .NUM_ENEMIES(3), .SPACING_H(150), .ENEMY_W(40), .ENEMY_H(30),
        .STEP_H(10), .STEP_V(20), .LEFT_BOUND(50), .RIGHT_BOUND(750),
        .LOSE_V(50), .START_H(50), .START_V(475),
        .BASE_PERIOD(4), .PERIOD_DEC(1), .MIN_PERIOD(2)
    ) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .proj_valid(proj_valid_a), .proj_h(proj_h_a), .proj_v(proj_v_a),
        .fleet_h(fleet_h_a), .fleet_v(fleet_v_a),
        .alive_mask(alive_mask_a), .alive_count(alive_count_a),
        .hit_pulse(hit_pulse_a), .hit_index(hit_index_a),
        .win(win_a), .lose(lose_a)
    );

    enemy_fleet_grid #(
        .NUM_ENEMIES(2), .SPACING_H(30), .ENEMY_W(40), .ENEMY_H(30),
        .STEP_H(10), .STEP_V(20), .LEFT_BOUND(75), .RIGHT_BOUND(90),
        .LOSE_V(50), .START_H(50), .START_V(90),
        .BASE_PERIOD(4), .PERIOD_DEC(0), .MIN_PERIOD(1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .proj_valid(proj_valid_b), .proj_h(proj_h_b), .proj_v(proj_v_b),
        .fleet_h(fleet_h_b), .fleet_v(fleet_v_b),
        .alive_mask(alive_mask_b), .alive_count(alive_count_b),
        .hit_pulse(hit_pulse_b), .hit_index(hit_index_b),
        .win(win_b), .lose(lose_b)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel_b, input logic valid,
                                 input logic [9:0] h, input logic [9:0] v);
        if (sel_b) begin
            proj_valid_b = valid;
            proj_h_b     = h;
            proj_v_b     = v;
        end else begin
            proj_valid_a = valid;
            proj_h_a     = h;
            proj_v_a     = v;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset_a = 1'b1; start_a = 1'b0;
        reset_b = 1'b1; start_b = 1'b0;
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd0);
        #12;

        // Reset values on both instances.
        checkOutput("a_rst_h", 32'(fleet_h_a), 32'd50);
        checkOutput("a_rst_v", 32'(fleet_v_a), 32'd475);
        checkOutput("a_rst_mask", 32'(alive_mask_a), 32'b111);
        checkOutput("a_rst_count", 32'(alive_count_a), 32'd3);
        checkOutput("a_rst_pulse", 32'(hit_pulse_a), 32'd0);
        checkOutput("a_rst_index", 32'(hit_index_a), 32'd0);
        checkOutput("a_rst_win", 32'(win_a), 32'd0);
        checkOutput("a_rst_lose", 32'(lose_a), 32'd0);
        checkOutput("b_rst_v", 32'(fleet_v_b), 32'd90);
        checkOutput("b_rst_mask", 32'(alive_mask_b), 32'b11);

        // Instance A: start for one edge, then the block walks right every 4 clocks.
        reset_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        checkOutput("a_move_e3", 32'(fleet_h_a), 32'd50);
        tick();
        checkOutput("a_move_e4", 32'(fleet_h_a), 32'd60);
        repeat (4) tick();
        checkOutput("a_move_e8", 32'(fleet_h_a), 32'd70);
        checkOutput("a_move_e8_v", 32'(fleet_v_a), 32'd475);

        // Destroy enemy 2 (origin 70+300=370).
        applyStimulus(1'b0, 1'b1, 10'd375, 10'd480);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
        checkOutput("a_hit2_pulse", 32'(hit_pulse_a), 32'd1);
        checkOutput("a_hit2_index", 32'(hit_index_a), 32'd2);
        checkOutput("a_hit2_mask", 32'(alive_mask_a), 32'b011);
        checkOutput("a_hit2_count", 32'(alive_count_a), 32'd2);
        tick();
        checkOutput("a_pulse_once", 32'(hit_pulse_a), 32'd0);

        // Period is now 3: next move lands on edge 11.
        tick();
        checkOutput("a_period3_h", 32'(fleet_h_a), 32'd80);

        // Enemy 1 is now the rightmost alive; it stops the block at fleet_h=600.
        repeat (156) tick();
        checkOutput("a_edge_h", 32'(fleet_h_a), 32'd600);
        checkOutput("a_edge_v", 32'(fleet_v_a), 32'd475);
        repeat (3) tick();
        checkOutput("a_rev_h", 32'(fleet_h_a), 32'd600);
        checkOutput("a_rev_v", 32'(fleet_v_a), 32'd455);
        repeat (3) tick();
        checkOutput("a_left_h", 32'(fleet_h_a), 32'd590);

        // Destroy enemy 1 (origin 740).
        applyStimulus(1'b0, 1'b1, 10'd745, 10'd460);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
        checkOutput("a_hit1_index", 32'(hit_index_a), 32'd1);
        checkOutput("a_hit1_mask", 32'(alive_mask_a), 32'b001);
        checkOutput("a_hit1_count", 32'(alive_count_a), 32'd1);

        // Period is now 2.
        tick();
        checkOutput("a_period2_h", 32'(fleet_h_a), 32'd580);

        // Destroy the last enemy (origin 580).
        applyStimulus(1'b0, 1'b1, 10'd585, 10'd460);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
        checkOutput("a_hit0_pulse", 32'(hit_pulse_a), 32'd1);
        checkOutput("a_hit0_index", 32'(hit_index_a), 32'd0);
        checkOutput("a_hit0_mask", 32'(alive_mask_a), 32'b000);
        checkOutput("a_hit0_win", 32'(win_a), 32'd0);
        tick();
        checkOutput("a_win", 32'(win_a), 32'd1);
        checkOutput("a_win_pulse", 32'(hit_pulse_a), 32'd0);
        repeat (4) tick();
        checkOutput("a_win_held", 32'(win_a), 32'd1);
        checkOutput("a_win_frozen_h", 32'(fleet_h_a), 32'd580);
        checkOutput("a_win_lose", 32'(lose_a), 32'd0);

        // Restart to INIT.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checkOutput("a_init_win", 32'(win_a), 32'd0);
        checkOutput("a_init_mask", 32'(alive_mask_a), 32'b111);
        checkOutput("a_init_count", 32'(alive_count_a), 32'd3);
        checkOutput("a_init_h", 32'(fleet_h_a), 32'd50);
        checkOutput("a_init_v", 32'(fleet_v_a), 32'd475);
        tick();
        checkOutput("a_init_stays_h", 32'(fleet_h_a), 32'd50);

        // Instance B: overlapping hitboxes, lowest index taken.
        reset_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        applyStimulus(1'b1, 1'b1, 10'd85, 10'd100);
        tick();
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd0);
        checkOutput("b_overlap_pulse", 32'(hit_pulse_b), 32'd1);
        checkOutput("b_overlap_index", 32'(hit_index_b), 32'd0);
        checkOutput("b_overlap_mask", 32'(alive_mask_b), 32'b10);
        checkOutput("b_overlap_count", 32'(alive_count_b), 32'd1);

        // Right bound 90 with enemy 1 at fleet_h+30; left bound 75 on enemy 1.
        repeat (3) tick();
        checkOutput("b_e4_h", 32'(fleet_h_b), 32'd60);
        checkOutput("b_e4_v", 32'(fleet_v_b), 32'd90);
        repeat (4) tick();
        checkOutput("b_e8_h", 32'(fleet_h_b), 32'd60);
        checkOutput("b_e8_v", 32'(fleet_v_b), 32'd70);
        repeat (4) tick();
        checkOutput("b_e12_h", 32'(fleet_h_b), 32'd50);
        checkOutput("b_e12_v", 32'(fleet_v_b), 32'd70);
        repeat (4) tick();
        checkOutput("b_e16_v", 32'(fleet_v_b), 32'd50);
        checkOutput("b_e16_lose", 32'(lose_b), 32'd0);
        tick();
        checkOutput("b_lose", 32'(lose_b), 32'd1);
        checkOutput("b_lose_win", 32'(win_b), 32'd0);
        repeat (4) tick();
        checkOutput("b_lose_held", 32'(lose_b), 32'd1);
        checkOutput("b_lose_frozen_v", 32'(fleet_v_b), 32'd50);
        checkOutput("b_lose_frozen_h", 32'(fleet_h_b), 32'd50);

        // Restart, run, then assert reset between edges.
        start_b = 1'b1;
        tick();
        checkOutput("b_init_lose", 32'(lose_b), 32'd0);
        checkOutput("b_init_v", 32'(fleet_v_b), 32'd90);
        tick();
        start_b = 1'b0;
        repeat (4) tick();
        checkOutput("b_rerun_h", 32'(fleet_h_b), 32'd60);
        #2;
        reset_b = 1'b1;
        #1;
        checkOutput("b_async_h", 32'(fleet_h_b), 32'd50);
        checkOutput("b_async_v", 32'(fleet_v_b), 32'd90);
        checkOutput("b_async_mask", 32'(alive_mask_b), 32'b11);
        checkOutput("b_async_count", 32'(alive_count_b), 32'd2);
        checkOutput("b_async_lose", 32'(lose_b), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
